// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and requester encoding for the writeback arbiter
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Requester identity; the value doubles as the bit index into grant vectors.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // One-hot register mask used for scoreboard set/clear.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    reg_onehot = NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input writeback arbiter, round-robin or fixed MEM priority
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rr_en,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_grant
);

  // Requester that won the most recent accepted transfer.
  req_e r_last;

  // Grant is purely combinational from the requests and the last winner.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11: begin
        // On a tie, round-robin favours whoever did not win last; fixed mode always favours MEM.
        if (i_rr_en && (r_last == REQ_MEM)) o_grant = 2'b01;
        else                                o_grant = 2'b10;
      end
      default: o_grant = 2'b00;
    endcase
  end

  // Pointer only moves when a grant actually turns into a transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= REQ_ALU;
    end else if (i_accept) begin
      r_last <= o_grant[1] ? REQ_MEM : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file writeback arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter bit RR_EN = 1'b1
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               ALU_VALID,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] ALU_RD,
  input  logic [XLEN-1:0]                    ALU_DATA,
  output logic                               ALU_READY,
  input  logic                               MEM_VALID,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] MEM_RD,
  input  logic [XLEN-1:0]                    MEM_DATA,
  output logic                               MEM_READY,
  input  logic                               ISSUE_VALID,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] ISSUE_RD,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] ISSUE_RS1,
  input  logic [regfile_pkg::REG_ADDR_W-1:0] ISSUE_RS2,
  output logic                               HAZARD,
  output logic [regfile_pkg::NUM_REGS-1:0]   PENDING,
  output logic [regfile_pkg::REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]                    WD3,
  output logic                               EN
);

  import regfile_pkg::*;

  logic [1:0]            w_grant;
  logic                  w_xfer;
  logic [REG_ADDR_W-1:0] w_wb_rd;
  logic [XLEN-1:0]       w_wb_data;
  logic                  w_wb_write;
  logic                  w_hazard;
  logic                  w_issue_ok;
  logic [NUM_REGS-1:0]   w_set_mask;
  logic [NUM_REGS-1:0]   w_clr_mask;
  logic [NUM_REGS-1:0]   w_pending_nxt;

  logic                  r_en;
  logic [REG_ADDR_W-1:0] r_a3;
  logic [XLEN-1:0]       r_wd3;
  logic [NUM_REGS-1:0]   r_pending;

  rr_arbiter2 u_arb (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_rr_en  (RR_EN),
    .i_req    ({MEM_VALID, ALU_VALID}),
    .i_accept (w_xfer),
    .o_grant  (w_grant)
  );

  // Ready is withheld while reset is asserted so nothing is consumed during reset.
  assign ALU_READY = RST_N & w_grant[0];
  assign MEM_READY = RST_N & w_grant[1];
  assign w_xfer    = ALU_READY | MEM_READY;

  // Select the winning requester's destination and data.
  always_comb begin
    w_wb_rd   = ALU_RD;
    w_wb_data = ALU_DATA;
    if (w_grant[1]) begin
      w_wb_rd   = MEM_RD;
      w_wb_data = MEM_DATA;
    end
  end

  // x0 writebacks are consumed but never reach the register file.
  assign w_wb_write = w_xfer && (w_wb_rd != '0);

  // Write port: one-cycle EN pulse per real write; address and data hold between writes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_en  <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
    end else begin
      r_en <= w_wb_write;
      if (w_wb_write) begin
        r_a3  <= w_wb_rd;
        r_wd3 <= w_wb_data;
      end
    end
  end

  assign w_hazard   = r_pending[ISSUE_RS1] | r_pending[ISSUE_RS2] | r_pending[ISSUE_RD];
  assign w_issue_ok = ISSUE_VALID && !w_hazard;
  assign w_set_mask = (w_issue_ok && (ISSUE_RD != '0)) ? reg_onehot(ISSUE_RD) : '0;
  assign w_clr_mask = r_en ? reg_onehot(r_a3) : '0;

  // Clear first, then set, so a new issue to the register being written keeps it pending.
  assign w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);

  // Scoreboard register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign HAZARD  = w_hazard;
  assign PENDING = r_pending;
  assign A3      = r_a3;
  assign WD3     = r_wd3;
  assign EN      = r_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            alu_valid, mem_valid, issue_valid;
  logic [4:0]      alu_rd, mem_rd, issue_rd, issue_rs1, issue_rs2;
  logic [XLEN-1:0] alu_data, mem_data;

  logic            rr_alu_ready, rr_mem_ready, rr_hazard, rr_en;
  logic [31:0]     rr_pending;
  logic [4:0]      rr_a3;
  logic [XLEN-1:0] rr_wd3;
  logic            fx_alu_ready, fx_mem_ready, fx_hazard, fx_en;
  logic [31:0]     fx_pending;
  logic [4:0]      fx_a3;
  logic [XLEN-1:0] fx_wd3;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state (round-robin instance).
  bit              m_pend [32];
  bit              m_en;
  logic [4:0]      m_a3;
  logic [XLEN-1:0] m_wd3;
  bit              m_last_mem;

  always #5 CLK = ~CLK;

  regfile_wb_arbiter #(.XLEN(XLEN), .RR_EN(1'b1)) dut_rr (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_VALID(alu_valid), .ALU_RD(alu_rd), .ALU_DATA(alu_data), .ALU_READY(rr_alu_ready),
    .MEM_VALID(mem_valid), .MEM_RD(mem_rd), .MEM_DATA(mem_data), .MEM_READY(rr_mem_ready),
    .ISSUE_VALID(issue_valid), .ISSUE_RD(issue_rd), .ISSUE_RS1(issue_rs1), .ISSUE_RS2(issue_rs2),
    .HAZARD(rr_hazard), .PENDING(rr_pending), .A3(rr_a3), .WD3(rr_wd3), .EN(rr_en)
  );

  regfile_wb_arbiter #(.XLEN(XLEN), .RR_EN(1'b0)) dut_fx (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_VALID(alu_valid), .ALU_RD(alu_rd), .ALU_DATA(alu_data), .ALU_READY(fx_alu_ready),
    .MEM_VALID(mem_valid), .MEM_RD(mem_rd), .MEM_DATA(mem_data), .MEM_READY(fx_mem_ready),
    .ISSUE_VALID(issue_valid), .ISSUE_RD(issue_rd), .ISSUE_RS1(issue_rs1), .ISSUE_RS2(issue_rs2),
    .HAZARD(fx_hazard), .PENDING(fx_pending), .A3(fx_a3), .WD3(fx_wd3), .EN(fx_en)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  function automatic logic [31:0] pack_pend();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic run_random(input int n_cycles);
    bit hz, g_alu, g_mem;
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_en = 1'b0; m_a3 = '0; m_wd3 = '0; m_last_mem = 1'b0;
    for (int c = 0; c < n_cycles; c++) begin
      check("rnd_en", rr_en, m_en);
      check("rnd_a3", rr_a3, m_a3);
      check("rnd_wd3", rr_wd3, m_wd3);
      check("rnd_pending", rr_pending, pack_pend());
      if (!alu_valid && ($urandom_range(0, 1) == 1)) begin
        alu_valid = 1'b1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!mem_valid && ($urandom_range(0, 1) == 1)) begin
        mem_valid = 1'b1; mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd  = 5'($urandom_range(0, 7));
      issue_rs1 = 5'($urandom_range(0, 7));
      issue_rs2 = 5'($urandom_range(0, 7));
      #1;
      hz = m_pend[issue_rs1] | m_pend[issue_rs2] | m_pend[issue_rd];
      g_alu = alu_valid && (!mem_valid || m_last_mem);
      g_mem = mem_valid && (!alu_valid || !m_last_mem);
      check("rnd_alu_ready", rr_alu_ready, g_alu);
      check("rnd_mem_ready", rr_mem_ready, g_mem);
      check("rnd_hazard", rr_hazard, hz);
      check("rnd_fx_mem_ready", fx_mem_ready, mem_valid);
      check("rnd_fx_alu_ready", fx_alu_ready, alu_valid && !mem_valid);
      if (m_en) m_pend[m_a3] = 1'b0;
      if (issue_valid && !hz && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      m_en = 1'b0;
      if (g_alu || g_mem) begin
        m_last_mem = g_mem;
        if (g_mem && mem_rd != 0) begin m_en = 1'b1; m_a3 = mem_rd; m_wd3 = mem_data; end
        if (g_alu && alu_rd != 0) begin m_en = 1'b1; m_a3 = alu_rd; m_wd3 = alu_data; end
      end
      tick();
      if (g_alu) alu_valid = 1'b0;
      if (g_mem) mem_valid = 1'b0;
    end
  endtask

  initial begin
    bit [3:0] exp_rr_mem;
    exp_rr_mem = 4'b0101;

    // Reset state, with requests present.
    clear_inputs();
    RST_N = 1'b0;
    alu_valid = 1'b1; mem_valid = 1'b1;
    #3;
    check("rst_alu_ready", rr_alu_ready, 1'b0);
    check("rst_mem_ready", rr_mem_ready, 1'b0);
    check("rst_en", rr_en, 1'b0);
    check("rst_a3", rr_a3, 5'd0);
    check("rst_wd3", rr_wd3, 32'd0);
    check("rst_pending", rr_pending, 32'd0);
    apply_reset();

    // Single ALU writeback, latency 1, single-cycle EN.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("alu_ready", rr_alu_ready, 1'b1);
    check("alu_mem_ready", rr_mem_ready, 1'b0);
    tick();
    alu_valid = 1'b0;
    check("alu_en", rr_en, 1'b1);
    check("alu_a3", rr_a3, 5'd5);
    check("alu_wd3", rr_wd3, 32'hDEADBEEF);
    tick();
    check("alu_en_drop", rr_en, 1'b0);
    check("alu_a3_hold", rr_a3, 5'd5);
    check("alu_wd3_hold", rr_wd3, 32'hDEADBEEF);

    // Tie behaviour in both modes.
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("tie_rr_mem", rr_mem_ready, exp_rr_mem[i]);
      check("tie_rr_alu", rr_alu_ready, !exp_rr_mem[i]);
      check("tie_fx_mem", fx_mem_ready, 1'b1);
      check("tie_fx_alu", fx_alu_ready, 1'b0);
      tick();
    end
    clear_inputs();

    // Hazard held until MEM writes the pending register.
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    check("hz_first_issue", rr_hazard, 1'b0);
    tick();
    issue_rd = 5'd0; issue_rs1 = 5'd7;
    check("hz_pend7", rr_pending, 32'h80);
    #1;
    check("hz_set", rr_hazard, 1'b1);
    tick();
    check("hz_hold", rr_hazard, 1'b1);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hC0FFEE;
    #1;
    check("hz_mem_ready", rr_mem_ready, 1'b1);
    tick();
    mem_valid = 1'b0;
    check("hz_wb_en", rr_en, 1'b1);
    check("hz_wb_a3", rr_a3, 5'd7);
    check("hz_during_en", rr_hazard, 1'b1);
    check("hz_pend_during_en", rr_pending, 32'h80);
    tick();
    check("hz_pend_cleared", rr_pending, 32'h0);
    check("hz_cleared", rr_hazard, 1'b0);
    issue_valid = 1'b0; issue_rs1 = 5'd0;

    // Issue and write to the same register in one cycle: set wins.
    apply_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    tick();
    alu_valid = 1'b0;
    check("sw_en", rr_en, 1'b1);
    check("sw_a3", rr_a3, 5'd3);
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    check("sw_hazard", rr_hazard, 1'b0);
    tick();
    issue_valid = 1'b0; issue_rd = 5'd0;
    check("sw_pending", rr_pending, 32'h8);

    // x0 writeback: accepted, no write, scoreboard untouched.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    check("x0_ready", rr_alu_ready, 1'b1);
    tick();
    alu_valid = 1'b0;
    check("x0_en", rr_en, 1'b0);
    check("x0_pending", rr_pending, 32'h8);
    check("x0_a3_hold", rr_a3, 5'd3);
    check("x0_wd3_hold", rr_wd3, 32'h33);

    // Asynchronous reset in the middle of an EN cycle.
    apply_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0; issue_rd = 5'd0;
    check("ar_pending", rr_pending, 32'h1200);
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    tick();
    mem_valid = 1'b0;
    check("ar_en_before", rr_en, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_en", rr_en, 1'b0);
    check("ar_pending_clr", rr_pending, 32'h0);
    check("ar_a3", rr_a3, 5'd0);
    check("ar_wd3", rr_wd3, 32'd0);
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    check("ar_no_write1", rr_en, 1'b0);
    tick();
    check("ar_no_write2", rr_en, 1'b0);
    check("ar_pending_after", rr_pending, 32'h0);

    // Randomized traffic against the reference model.
    apply_reset();
    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
